// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: accepts a WIDTH-bit word over valid/ready and
// shifts it out as start(0), WIDTH data bits, stop(1), each held CYCLES_PER_BIT clocks.
module serial_frame_tx #(
    parameter int WIDTH          = 8,
    parameter int CYCLES_PER_BIT = 1,
    parameter int MSB_FIRST      = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             d_out,
    output logic             busy,
    output logic             done
);

    localparam int CW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(CYCLES_PER_BIT - 1);
    localparam logic [CW-1:0] CYC_ZERO = CW'(0);
    localparam logic [CW-1:0] CYC_ONE  = CW'(1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [BW-1:0] BIT_ZERO = BW'(0);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cyc_q, cyc_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [WIDTH-1:0]  sh_q, sh_d;
    logic [WIDTH-1:0]  sh_shift_s;
    logic              d_out_q, d_out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic              bit_end_s;

    // The bit on the line is always taken from the head of the shift register.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        logic b;
        if (MSB_FIRST != 0) begin
            b = w[WIDTH-1];
        end else begin
            b = w[0];
        end
        return b;
    endfunction

    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] r;
        if (MSB_FIRST != 0) begin
            r = w << 1;
        end else begin
            r = w >> 1;
        end
        return r;
    endfunction

    assign bit_end_s  = (cyc_q == CYC_LAST);
    assign sh_shift_s = shift_word(sh_q);

    // Next-state logic; d_out_d is the value the line will carry after this edge.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        d_out_d = 1'b1;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ready_d = ready_q;
        case (state_q)
            IDLE: begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
                cyc_d   = CYC_ZERO;
                bit_d   = BIT_ZERO;
                if (load_valid) begin
                    sh_d    = data_in;
                    state_d = START;
                    d_out_d = 1'b0;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                end else begin
                    d_out_d = 1'b1;
                end
            end
            START: begin
                if (bit_end_s) begin
                    cyc_d   = CYC_ZERO;
                    bit_d   = BIT_ZERO;
                    state_d = DATA;
                    d_out_d = head_bit(sh_q);
                end else begin
                    cyc_d   = cyc_q + CYC_ONE;
                    d_out_d = 1'b0;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    cyc_d = CYC_ZERO;
                    sh_d  = sh_shift_s;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = BIT_ZERO;
                        state_d = STOP;
                        d_out_d = 1'b1;
                    end else begin
                        bit_d   = bit_q + BIT_ONE;
                        d_out_d = head_bit(sh_shift_s);
                    end
                end else begin
                    cyc_d   = cyc_q + CYC_ONE;
                    d_out_d = head_bit(sh_q);
                end
            end
            STOP: begin
                d_out_d = 1'b1;
                if (bit_end_s) begin
                    cyc_d   = CYC_ZERO;
                    state_d = IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    cyc_d = cyc_q + CYC_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cyc_d   = CYC_ZERO;
                bit_d   = BIT_ZERO;
                d_out_d = 1'b1;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cyc_q   <= CYC_ZERO;
            bit_q   <= BIT_ZERO;
            sh_q    <= {WIDTH{1'b0}};
            d_out_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            d_out_q <= d_out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign d_out      = d_out_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign load_ready = ready_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: three configurations (LSB-first, MSB-first, 4 cycles/bit)
// checked cycle by cycle against a queue of expected line values.
module tb_serial_frame_tx;

    logic       clk;
    logic       rst;
    logic [2:0] lv;
    logic [7:0] din [3];
    wire  [2:0] rdy;
    wire  [2:0] dout;
    wire  [2:0] busy;
    wire  [2:0] done;

    int n_cmp;
    int n_err;
    bit sb[$];

    serial_frame_tx #(.WIDTH(8), .CYCLES_PER_BIT(1), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .data_in(din[0]), .load_valid(lv[0]),
        .load_ready(rdy[0]), .d_out(dout[0]), .busy(busy[0]), .done(done[0]));

    serial_frame_tx #(.WIDTH(8), .CYCLES_PER_BIT(1), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .data_in(din[1]), .load_valid(lv[1]),
        .load_ready(rdy[1]), .d_out(dout[1]), .busy(busy[1]), .done(done[1]));

    serial_frame_tx #(.WIDTH(8), .CYCLES_PER_BIT(4), .MSB_FIRST(0)) u_c4 (
        .clk(clk), .rst(rst), .data_in(din[2]), .load_valid(lv[2]),
        .load_ready(rdy[2]), .d_out(dout[2]), .busy(busy[2]), .done(done[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit exp_bit(input logic [7:0] data, input bit msb, input int k);
        logic [7:0] d;
        d = data;
        return msb ? d[7-k] : d[k];
    endfunction

    // Called one cycle after the accepting edge. mode: 0 quiet, 1 scramble data_in,
    // 2 pulse load_valid with 8'hEE mid-frame. Ends in the done cycle.
    task automatic check_frame(input int idx, input logic [7:0] data, input bit msb,
                               input int c, input int mode);
        bit b;
        bit e;
        for (int k = 0; k < 10; k++) begin
            if (k == 0) b = 1'b0;
            else if (k == 9) b = 1'b1;
            else b = exp_bit(data, msb, k - 1);
            for (int r = 0; r < c; r++) sb.push_back(b);
        end
        for (int i = 0; i < c * 10; i++) begin
            e = sb.pop_front();
            n_cmp++;
            if (dout[idx] !== e) begin
                n_err++;
                $display("FAIL d_out dut%0d data=%h cycle %0d: got %b want %b", idx, data, i + 1, dout[idx], e);
            end
            n_cmp++;
            if ({busy[idx], done[idx], rdy[idx]} !== 3'b100) begin
                n_err++;
                $display("FAIL busy/done/ready dut%0d cycle %0d: got %b want 100", idx, i + 1,
                         {busy[idx], done[idx], rdy[idx]});
            end
            if (mode == 1) begin
                din[idx] = 8'($urandom);
            end else if (mode == 2 && i == 3) begin
                lv[idx]  = 1'b1;
                din[idx] = 8'hEE;
            end else if (mode == 2 && i == 4) begin
                lv[idx] = 1'b0;
            end
            tick();
        end
        n_cmp++;
        if ({dout[idx], busy[idx], done[idx], rdy[idx]} !== 4'b1011) begin
            n_err++;
            $display("FAIL done-cycle dut%0d: got d/b/dn/r=%b want 1011", idx,
                     {dout[idx], busy[idx], done[idx], rdy[idx]});
        end
    endtask

    task automatic start_load(input int idx, input logic [7:0] data);
        lv[idx]  = 1'b1;
        din[idx] = data;
        tick();
        lv[idx] = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({dout, rdy, busy, done} !== {3'b111, 3'b111, 3'b000, 3'b000}) begin
            n_err++;
            $display("FAIL reset state: got %b want 111111000000", {dout, rdy, busy, done});
        end
        lv[0]  = 1'b1;
        din[0] = 8'hA5;
        tick();
        rst = 1'b0;
        tick();
        lv[0] = 1'b0;
        check_frame(0, 8'hA5, 1'b0, 1, 0);
        tick();
        n_cmp++;
        if ({done[0], busy[0]} !== 2'b00) begin
            n_err++;
            $display("FAIL done width: got done/busy=%b want 00", {done[0], busy[0]});
        end
    endtask

    task automatic test_msb();
        start_load(1, 8'hA5);
        check_frame(1, 8'hA5, 1'b1, 1, 0);
        start_load(1, 8'h01);
        check_frame(1, 8'h01, 1'b1, 1, 0);
    endtask

    task automatic test_slow();
        start_load(2, 8'h3C);
        check_frame(2, 8'h3C, 1'b0, 4, 1);
    endtask

    task automatic test_back_to_back();
        lv[0]  = 1'b1;
        din[0] = 8'h11;
        tick();
        din[0] = 8'h22;
        check_frame(0, 8'h11, 1'b0, 1, 0);
        tick();
        lv[0] = 1'b0;
        check_frame(0, 8'h22, 1'b0, 1, 1);
    endtask

    task automatic test_abort();
        tick();
        start_load(0, 8'hFF);
        repeat (4) tick();
        n_cmp++;
        if ({dout[0], busy[0]} !== 2'b11) begin
            n_err++;
            $display("FAIL bit3 before abort: got d/busy=%b want 11", {dout[0], busy[0]});
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({dout[0], busy[0], rdy[0], done[0]} !== 4'b1010) begin
            n_err++;
            $display("FAIL async abort: got d/b/r/dn=%b want 1010", {dout[0], busy[0], rdy[0], done[0]});
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            n_cmp++;
            if ({dout[0], busy[0], done[0]} !== 3'b100) begin
                n_err++;
                $display("FAIL post-abort idle cycle %0d: got d/b/dn=%b want 100", i, {dout[0], busy[0], done[0]});
            end
            tick();
        end
        start_load(0, 8'h00);
        check_frame(0, 8'h00, 1'b0, 1, 0);
    endtask

    task automatic test_ignore_busy();
        tick();
        start_load(0, 8'h5A);
        check_frame(0, 8'h5A, 1'b0, 1, 2);
        tick();
        for (int i = 0; i < 12; i++) begin
            n_cmp++;
            if ({dout[0], busy[0], rdy[0]} !== 3'b101) begin
                n_err++;
                $display("FAIL no second frame cycle %0d: got d/b/r=%b want 101", i, {dout[0], busy[0], rdy[0]});
            end
            tick();
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard leftover: got %0d want 0", sb.size());
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        lv    = 3'b000;
        for (int i = 0; i < 3; i++) din[i] = 8'h00;
        test_reset();
        test_msb();
        test_slow();
        test_back_to_back();
        test_abort();
        test_ignore_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
